// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_pkg
//  Description : Shared definitions for the instruction encoder: format
//                codes, word prefixes, condition codes and error codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    // Instruction format selector carried on the fmt input
    typedef enum logic [2:0] {
        FMT_SINGLE      = 3'd0,
        FMT_SINGLE_BA   = 3'd1,
        FMT_DOUBLE      = 3'd2,
        FMT_TRIPLE      = 3'd3,
        FMT_DIRECT      = 3'd4,
        FMT_CONTROL     = 3'd5,
        FMT_CONTROL_OFF = 3'd6,
        FMT_ILLEGAL     = 3'd7
    } fmt_e;

    // Opcode prefixes occupying the top bits of each word layout
    localparam logic [2:0] c_pfx_single      = 3'b000;
    localparam logic [2:0] c_pfx_single_ba   = 3'b001;
    localparam logic [1:0] c_pfx_double      = 2'b01;
    localparam logic [1:0] c_pfx_triple      = 2'b10;
    localparam logic [1:0] c_pfx_direct      = 2'b11;
    localparam logic [4:0] c_pfx_control     = 5'b11110;
    localparam logic [4:0] c_pfx_control_off = 5'b11111;

    // Condition codes
    localparam logic [3:0] c_cond_always  = 4'b0110;
    localparam logic [3:0] c_cond_invalid = 4'b1110;

    // Error codes reported on err_code (first error wins)
    localparam logic [2:0] c_err_none   = 3'd0;
    localparam logic [2:0] c_err_cond   = 3'd1;
    localparam logic [2:0] c_err_fmt    = 3'd2;
    localparam logic [2:0] c_err_direct = 3'd3;
    localparam logic [2:0] c_err_full   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
//  Module      : instr_pack
//  Description : Purely combinational field-to-word packer with legality
//                check. Produces the 16-bit decoder word for one bundle and
//                a non-zero error code when the bundle cannot be encoded.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [5:0]  subop,
    input  logic [3:0]  cond,
    input  logic [2:0]  rd,
    input  logic [2:0]  rb,
    input  logic [2:0]  ra,
    input  logic [3:0]  bitaddr,
    input  logic [11:0] addr12,
    output logic [15:0] word,
    output logic [2:0]  err_code
);

    // DIRECT words carry no condition field; the decoder treats them as
    // "always", so that is the condition that gets checked for them.
    logic [3:0] w_cond_eff;
    assign w_cond_eff = (fmt == FMT_DIRECT) ? c_cond_always : cond;

    // Pack the fields into the layout selected by fmt
    always_comb begin
        word = 16'h0000;
        case (fmt)
            FMT_SINGLE:      word = {c_pfx_single, subop[5:0], cond, rd};
            FMT_SINGLE_BA:   word = {c_pfx_single_ba, subop[1:0], cond, rd, bitaddr};
            FMT_DOUBLE:      word = {c_pfx_double, subop[3:0], cond, rd, ra};
            FMT_TRIPLE:      word = {c_pfx_triple, subop[0], cond, rd, rb, ra};
            FMT_DIRECT:      word = {c_pfx_direct, subop[1:0], addr12};
            FMT_CONTROL:     word = {c_pfx_control, 1'b0, subop[5:0], cond};
            FMT_CONTROL_OFF: word = {c_pfx_control_off, subop[3:0], cond, addr12[2:0]};
            default:         word = 16'h0000;
        endcase
    end

    // Encoding legality; when several apply the lowest code is reported
    always_comb begin
        err_code = c_err_none;
        if (w_cond_eff == c_cond_invalid) begin
            err_code = c_err_cond;
        end else if (fmt == FMT_ILLEGAL) begin
            err_code = c_err_fmt;
        end else if ((fmt == FMT_DIRECT) && (subop[1:0] == 2'b11)) begin
            err_code = c_err_direct;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Program-loader front end. Accepts instruction field
//                bundles over valid/ready, packs them into 16-bit decoder
//                words and writes them (plus optional immediates)
//                sequentially into instruction RAM.
//  Options     : INSTR_ENCODER_CHECKSUM_EN adds a checksum output holding
//                the running XOR of every word written since start/reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MEM_DEPTH = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        fmt,
    input  logic [5:0]        subop,
    input  logic [3:0]        cond,
    input  logic [2:0]        rd,
    input  logic [2:0]        rb,
    input  logic [2:0]        ra,
    input  logic [3:0]        bitaddr,
    input  logic [11:0]       addr12,
    input  logic              has_imm,
    input  logic [15:0]       imm,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_data,
    output logic [ADDR_W:0]   prog_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wr1  = 2'd1;
    localparam logic [1:0] c_st_wr2  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [ADDR_W:0]   c_ptr_one = (ADDR_W+1)'(1);
    localparam logic [ADDR_W+1:0] c_depth   = (ADDR_W+2)'(MEM_DEPTH);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W:0]   r_ptr;
    logic [ADDR_W:0]   r_prog_len;
    logic [15:0]       r_word;
    logic [15:0]       r_imm;
    logic              r_has_imm;
    logic              r_last;
    logic              r_err;
    logic [2:0]        r_err_code;

    logic [15:0]       w_word;
    logic [2:0]        w_pack_code;
    logic              w_pack_err;
    logic [ADDR_W+1:0] w_ptr_ext;
    logic [ADDR_W+1:0] w_space;
    logic [ADDR_W+1:0] w_need;
    logic              w_room_err;
    logic              w_bundle_err;
    logic [2:0]        w_new_code;
    logic              w_accept;
    logic              w_writing;

    instr_pack u_pack (
        .fmt      (fmt),
        .subop    (subop),
        .cond     (cond),
        .rd       (rd),
        .rb       (rb),
        .ra       (ra),
        .bitaddr  (bitaddr),
        .addr12   (addr12),
        .word     (w_word),
        .err_code (w_pack_code)
    );

    // Space check: no wrap-around, so a bundle needing more words than are
    // left below MEM_DEPTH is refused. A pointer started beyond the depth
    // counts as full rather than underflowing the subtraction.
    assign w_ptr_ext    = {1'b0, r_ptr};
    assign w_space      = c_depth - w_ptr_ext;
    assign w_need       = has_imm ? (ADDR_W+2)'(2) : (ADDR_W+2)'(1);
    assign w_room_err   = (w_ptr_ext > c_depth) || (w_space < w_need);
    assign w_pack_err   = (w_pack_code != c_err_none);
    assign w_bundle_err = w_pack_err || w_room_err;
    assign w_new_code   = w_pack_err ? w_pack_code : c_err_full;

    // start wins over a handshake, so nothing is consumed in a start cycle
    assign in_ready  = (r_state == c_st_idle) && !reset && !start;
    assign w_accept  = in_valid && in_ready;
    assign w_writing = ((r_state == c_st_wr1) || (r_state == c_st_wr2)) && !start && !reset;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an erroring bundle is consumed without a write
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    if (w_bundle_err) begin
                        w_next_state = in_last ? c_st_done : c_st_idle;
                    end else begin
                        w_next_state = c_st_wr1;
                    end
                end
            end
            c_st_wr1: begin
                if (r_has_imm) begin
                    w_next_state = c_st_wr2;
                end else begin
                    w_next_state = r_last ? c_st_done : c_st_idle;
                end
            end
            c_st_wr2:  w_next_state = r_last ? c_st_done : c_st_idle;
            c_st_done: w_next_state = c_st_done;
            default:   w_next_state = c_st_idle;
        endcase
        if (start) begin
            w_next_state = c_st_idle;
        end
    end

    // Datapath: bundle latch, write pointer, length and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_prog_len <= '0;
            r_word     <= '0;
            r_imm      <= '0;
            r_has_imm  <= 1'b0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= c_err_none;
        end else if (start) begin
            r_ptr      <= {1'b0, start_addr};
            r_prog_len <= '0;
            r_err      <= 1'b0;
            r_err_code <= c_err_none;
        end else begin
            if (w_accept) begin
                r_last <= in_last;
                if (w_bundle_err) begin
                    r_err <= 1'b1;
                    if (!r_err) begin
                        r_err_code <= w_new_code;
                    end
                end else begin
                    r_word    <= w_word;
                    r_imm     <= imm;
                    r_has_imm <= has_imm;
                end
            end
            if (w_writing) begin
                r_ptr      <= r_ptr + c_ptr_one;
                r_prog_len <= r_prog_len + c_ptr_one;
            end
        end
    end

    // Write port and status outputs, all forced quiet while reset is high
    always_comb begin
        ram_wren = w_writing;
        ram_addr = reset ? '0 : r_ptr[ADDR_W-1:0];
        ram_data = 16'h0000;
        if (w_writing) begin
            ram_data = (r_state == c_st_wr2) ? r_imm : r_word;
        end
        prog_len = reset ? '0 : r_prog_len;
        busy     = !reset && ((r_state == c_st_wr1) || (r_state == c_st_wr2));
        done     = !reset && (r_state == c_st_done);
        err      = !reset && r_err;
        err_code = reset ? c_err_none : r_err_code;
    end

`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [15:0] r_checksum;

    // Running XOR of every word that reaches the RAM
    always_ff @(posedge clk) begin
        if (reset || start) begin
            r_checksum <= 16'h0000;
        end else if (w_writing) begin
            r_checksum <= r_checksum ^ ram_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Program-loader front end that is the write side of the CPU instruction decoder.
- Accepts instruction fields (format, sub-opcode, condition, registers, address/offset, optional immediate) over a valid/ready handshake.
- Packs the fields into the 16-bit instruction word layout the decoder expects and writes the words sequentially into instruction RAM.
- Sits between the host/debug loader and the instruction RAM write port; it is active only while the CPU is held stopped.

Parameters:
- ADDR_W, 12, instruction RAM address width; matches the 12-bit direct-address field.
- MEM_DEPTH, 4096, number of writable words; the last valid address is MEM_DEPTH-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; sets the write pointer to start_addr, clears err/done/prog_len, returns the FSM to IDLE
- start_addr  in  ADDR_W  first write address
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid & in_ready
- in_last  in  1  final instruction of the program
- fmt  in  3  0 SINGLE, 1 SINGLE_BA, 2 DOUBLE, 3 TRIPLE, 4 DIRECT, 5 CONTROL, 6 CONTROL_OFF, 7 illegal
- subop  in  6  format-specific opcode subfield
- cond  in  4  condition code; 4'b0110 = always
- rd, rb, ra  in  3 each  destination / second source / first source register
- bitaddr  in  4  bit index for SINGLE_BA
- addr12  in  12  DIRECT address; bits [2:0] are the CONTROL_OFF offset
- has_imm  in  1  append a second immediate word (ldi/aim/sim)
- imm  in  16  immediate word
- ram_wren  out  1  instruction RAM write strobe
- ram_addr  out  ADDR_W  write address
- ram_data  out  16  write data
- prog_len  out  ADDR_W+1  words written since the last start
- busy  out  1  FSM is not in IDLE or DONE
- done  out  1  in_last instruction has been written; held until start
- err  out  1  sticky error flag
- err_code  out  3  first error: 1 bad cond, 2 bad fmt, 3 DIRECT subop 11, 4 full

Behaviour:
Word packing (combinational, registered on accept):
- SINGLE = {000, subop[5:0], cond, rd}
- SINGLE_BA = {001, subop[1:0], cond, rd, bitaddr}
- DOUBLE = {01, subop[3:0], cond, rd, ra}
- TRIPLE = {10, subop[0], cond, rd, rb, ra}
- DIRECT = {11, subop[1:0], addr12}; cond is ignored because the decoder forces "always"
- CONTROL = {11110, 0, subop[5:0], cond}; rtn = subop 0, stp = subop 1
- CONTROL_OFF = {11111, subop[3:0], cond, addr12[2:0]}

FSM states: IDLE, WR1, WR2, DONE.
- in_ready = 1 only in IDLE with reset low.
- Accept in IDLE, error-free: latch the packed word and imm; go to WR1.
- WR1: ram_wren=1, ram_addr=ptr, ram_data=word; ptr+1, prog_len+1. Go to WR2 if has_imm, else DONE if last, else IDLE.
- WR2: ram_wren=1, ram_data=imm, ram_addr=ptr; ptr+1, prog_len+1. Go to DONE if last, else IDLE.
- Throughput: 2 cycles per one-word instruction, 3 cycles per two-word instruction.
- DONE: done=1, in_ready=0; leaves only on start.

Errors:
- Checked at accept: cond==1110 (except DIRECT), fmt==7, DIRECT subop==11, or remaining space (MEM_DEPTH-ptr) smaller than the words needed.
- On error: the bundle is consumed, nothing is written, the FSM stays in IDLE.
- err is set; err_code keeps the first error only.
- An in_last bundle that errors still moves the FSM to DONE.

Pointer and priority rules:
- No wrap-around. When ptr==MEM_DEPTH the block is full and every further instruction raises error 4.
- start has priority over all other events. A start during WR1/WR2 aborts the pending write: ram_wren=0 that cycle.

Reset:
- state IDLE, ptr=0.
- ram_wren=0, ram_addr=0, ram_data=0, prog_len=0.
- busy=0, done=0, err=0, err_code=0, in_ready=0 during reset.

Optional Feature:
- Macro: INSTR_ENCODER_CHECKSUM_EN.
- When defined: adds output checksum[15:0], the running XOR of every word written (including immediates). It is cleared by reset and start, and is valid when done=1.
- When undefined: the port and the logic are absent.

Decomposition:
- Shared package holds:
  - fmt enum codes;
  - format prefix constants (000, 001, 01, 10, 11, 11110, 11111);
  - COND_ALWAYS=4'b0110 and COND_INVALID=4'b1110;
  - err_code constants.
- One sub-module, instr_pack: purely combinational field-to-word packer plus legality check. It is reusable by a future on-chip assembler.

Test Plan:
- start (start_addr=0); DOUBLE add: subop=0000, cond=0110, rd=2, ra=1 -> WR1 writes 16'h4191 at addr 0; prog_len=1.
- SINGLE inc (subop=001000, cond=0110, rd=3) with has_imm=1, imm=16'hBEEF -> writes 16'h0433 at addr 0, then 16'hBEEF at addr 1 in the next cycle; in_ready low for 2 cycles.
- DIRECT call: subop=01, addr12=12'h123, in_last=1 -> writes 16'hD123; done=1; in_ready stays 0 until start.
- SINGLE with cond=1110 -> no ram_wren, err=1, err_code=1. A following legal instruction is still written; err_code stays 1.
- MEM_DEPTH=4: start_addr=3, then a has_imm instruction -> err_code=4, no write. A following one-word instruction writes addr 3; the next one is rejected as full.
- start pulse asserted during WR1 -> no write that cycle; ptr=start_addr, prog_len=0, err=0, FSM in IDLE.
